lectura_rtc: RTL

LECTURA_RTC -- requirements
Module: lectura_rtc

---
 rtl/lectura_rtc.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lectura_rtc.sv
// lectura_rtc: sweeps the RTC multiplexed bus, reading nine fixed registers
// and publishing each BCD byte with its display slot and a one-cycle strobe.
// All outputs are registered decodes of the current state, so the pins trail
// the state register by one cycle; ocupado rises on the accepting edge.
module lectura_rtc #(
  parameter int unsigned T_FASE = 10,
  parameter int unsigned N_REG  = 9
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       iniciar,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] DIR_DATO,
  output logic [3:0] POSICION,
  output logic       RD,
  output logic       ocupado
);

  typedef enum logic [2:0] {
    IDLE, DIR_SET, DIR_HOLD, PAUSA, LEER, PUBLICA, FIN
  } estado_t;

  localparam logic [7:0] FASE_ULT = 8'(T_FASE - 1);
  localparam logic [3:0] K_ULT    = 4'(N_REG);

  estado_t    estado, estado_sig;
  logic [7:0] fase;
  logic [3:0] k;
  logic       fase_fin;

  assign fase_fin = (fase == FASE_ULT);

  // sweep table: slot index -> RTC register address
  function automatic logic [7:0] dir_rtc(input logic [3:0] i);
    case (i)
      4'd1:    dir_rtc = 8'h23;
      4'd2:    dir_rtc = 8'h22;
      4'd3:    dir_rtc = 8'h21;
      4'd4:    dir_rtc = 8'h43;
      4'd5:    dir_rtc = 8'h42;
      4'd6:    dir_rtc = 8'h41;
      4'd7:    dir_rtc = 8'h24;
      4'd8:    dir_rtc = 8'h25;
      4'd9:    dir_rtc = 8'h26;
      default: dir_rtc = 8'h00;
    endcase
  endfunction

  // next-state: timed phases advance on the last phase cycle
  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:     if (iniciar)  estado_sig = DIR_SET;
      DIR_SET:  if (fase_fin) estado_sig = DIR_HOLD;
      DIR_HOLD: if (fase_fin) estado_sig = PAUSA;
      PAUSA:    if (fase_fin) estado_sig = LEER;
      LEER:     if (fase_fin) estado_sig = PUBLICA;
      PUBLICA:  estado_sig = (k < K_ULT) ? DIR_SET : FIN;
      FIN:      estado_sig = IDLE;
      default:  estado_sig = IDLE;
    endcase
  end

  // state, phase counter (cleared on every state change) and slot index
  always_ff @(posedge reloj) begin
    if (resetM) begin
      estado <= IDLE;
      fase   <= 8'd0;
      k      <= 4'd0;
    end else begin
      estado <= estado_sig;
      fase   <= (estado_sig != estado || estado == IDLE) ? 8'd0 : fase + 8'd1;
      if (estado == IDLE && iniciar)
        k <= 4'd1;
      else if (estado == PUBLICA && k < K_ULT)
        k <= k + 4'd1;
    end
  end

  // registered bus/strobe decode; the PUBLICA decode also latches ad_in,
  // which at that edge is the value seen during the last visible LEER cycle
  always_ff @(posedge reloj) begin
    if (resetM) begin
      ad_out   <= 8'h00;
      ad_oe    <= 1'b0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      a_d      <= 1'b1;
      DIR_DATO <= 8'h00;
      POSICION <= 4'd0;
      RD       <= 1'b1;
      ocupado  <= 1'b0;
    end else begin
      ad_out  <= 8'h00;
      ad_oe   <= 1'b0;
      cs_n    <= 1'b1;
      rd_n    <= 1'b1;
      wr_n    <= 1'b1;
      a_d     <= 1'b1;
      RD      <= 1'b1;
      ocupado <= (estado != IDLE) || iniciar;
      case (estado)
        DIR_SET: begin
          cs_n   <= 1'b0;
          a_d    <= 1'b0;
          wr_n   <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= dir_rtc(k);
        end
        DIR_HOLD: begin
          cs_n   <= 1'b0;
          a_d    <= 1'b0;
          ad_oe  <= 1'b1;
          ad_out <= dir_rtc(k);
        end
        LEER: begin
          cs_n <= 1'b0;
          rd_n <= 1'b0;
        end
        PUBLICA: begin
          DIR_DATO <= ad_in;
          POSICION <= k;
          RD       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
